// File: rtl/xmr_probe_arbiter_if.sv
// Handshake bundle between the probe arbiter, its requesters and the exported-signal probe mux.
// The arbiter connects through the slave modport; clients and the probe mux drive the master side.
interface xmr_probe_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*SEL_W-1:0] req_sel;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_err;
    logic                     probe_en;
    logic [SEL_W-1:0]         probe_sel;
    logic                     probe_ack;
    logic [DATA_W-1:0]        probe_data;
    logic                     busy;

    modport slave (
        input  req_valid, req_sel, rsp_ready, probe_ack, probe_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, probe_en, probe_sel, busy
    );

    modport master (
        output req_valid, req_sel, rsp_ready, probe_ack, probe_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, probe_en, probe_sel, busy
    );
endinterface

// File: rtl/xmr_probe_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one exported-signal probe port.
// Define XMR_PROBE_TIMEOUT_EN to abort a probe after TIMEOUT silent WAIT cycles (rsp_err=1).
//
// state | meaning
// IDLE  | no transaction; pick next requester round-robin after rr_ptr
// GRANT | req_ready pulse to the granted requester
// ISSUE | probe_en strobe with the latched select
// WAIT  | waiting for probe_ack (or timeout when enabled)
// RESP  | rsp_valid held to the granted requester until its rsp_ready
module xmr_probe_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    xmr_probe_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    gnt;
    logic [IDX_W-1:0]    pick;
    logic                pick_valid;
    logic [NUM_REQ-1:0]  req_ready_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                probe_en_q;
    logic [SEL_W-1:0]    probe_sel_q;

`ifdef XMR_PROBE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Descending search so the nearest set bit after rr_ptr is the last one written.
    always_comb begin
        pick       = rr_ptr;
        pick_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick       = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            gnt         <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            probe_en_q  <= 1'b0;
            probe_sel_q <= '0;
`ifdef XMR_PROBE_TIMEOUT_EN
            wait_cnt    <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt         <= pick;
                        probe_sel_q <= bus.req_sel[int'(pick)*SEL_W +: SEL_W];
                        req_ready_q <= ONE_HOT0 << pick;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    req_ready_q <= '0;
                    probe_en_q  <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    probe_en_q <= 1'b0;
`ifdef XMR_PROBE_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= WAIT;
                end
                WAIT: begin
                    if (bus.probe_ack) begin
                        rsp_data_q  <= bus.probe_data;
                        rsp_valid_q <= ONE_HOT0 << gnt;
`ifdef XMR_PROBE_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= RESP;
`ifdef XMR_PROBE_TIMEOUT_EN
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_data_q  <= '1;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= ONE_HOT0 << gnt;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[gnt]) begin
                        rsp_valid_q <= '0;
                        rr_ptr      <= gnt;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.probe_en  = probe_en_q;
    assign bus.probe_sel = probe_sel_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_xmr_probe_arbiter.sv
// Directed bench for xmr_probe_arbiter: vector table for grant order and data path,
// hand sequences for backpressure, mid-WAIT reset and the optional probe timeout.
module tb_xmr_probe_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    xmr_probe_arbiter_if #(.NUM_REQ(4), .SEL_W(4), .DATA_W(8)) bus ();

    xmr_probe_arbiter #(.NUM_REQ(4), .SEL_W(4), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] sel;
        int          ack_dly;
        logic [7:0]  data;
        int          rdy_dly;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name, input logic [3:0] exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.req_ready == 4'b0 && n < 20);
        check({name, "_req_ready"}, bus.req_ready, exp);
        check({name, "_grant_latency"}, n, 1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        string nm;
        nm = $sformatf("vec%0d", id);
        bus.req_valid = v.vld;
        bus.req_sel   = v.sel;
        bus.rsp_ready = 4'b0;
        bus.probe_ack = 1'b0;
        wait_grant(nm, v.exp_gnt);
        tick();
        check({nm, "_issue"}, {bus.req_ready, bus.probe_en, bus.probe_sel}, {4'b0, 1'b1, v.exp_sel});
        repeat (v.ack_dly) tick();
        bus.probe_ack  = 1'b1;
        bus.probe_data = v.data;
        tick();
        bus.probe_ack  = 1'b0;
        bus.probe_data = ~v.data;
        check({nm, "_rsp"}, {bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy},
              {v.exp_gnt, v.data, 1'b0, 1'b1});
        for (int k = 0; k < v.rdy_dly; k++) begin
            bus.rsp_ready = ~v.exp_gnt;
            tick();
            check({nm, "_rsp_hold"}, {bus.rsp_valid, bus.rsp_data, bus.probe_en, bus.busy},
                  {v.exp_gnt, v.data, 1'b0, 1'b1});
        end
        bus.rsp_ready = v.exp_gnt;
        tick();
        bus.rsp_ready = 4'b0;
        check({nm, "_idle"}, {bus.rsp_valid, bus.busy, bus.rsp_data}, {4'b0, 1'b0, v.data});
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 16'h0003, 2, 8'hA5, 0, 4'b0001, 4'h3};
        vecs[1]  = '{4'b1111, 16'hDCBA, 1, 8'h11, 0, 4'b0010, 4'hB};
        vecs[2]  = '{4'b1111, 16'hDCBA, 1, 8'h22, 0, 4'b0100, 4'hC};
        vecs[3]  = '{4'b1111, 16'hDCBA, 1, 8'h33, 0, 4'b1000, 4'hD};
        vecs[4]  = '{4'b1111, 16'hDCBA, 1, 8'h44, 0, 4'b0001, 4'hA};
        vecs[5]  = '{4'b1111, 16'hDCBA, 1, 8'h55, 0, 4'b0010, 4'hB};
        vecs[6]  = '{4'b0100, 16'h0700, 1, 8'h66, 0, 4'b0100, 4'h7};
        vecs[7]  = '{4'b0011, 16'h0095, 1, 8'h77, 0, 4'b0001, 4'h5};
        vecs[8]  = '{4'b0011, 16'h0095, 1, 8'h88, 0, 4'b0010, 4'h9};
        vecs[9]  = '{4'b0010, 16'h0095, 3, 8'h00, 0, 4'b0010, 4'h9};
        vecs[10] = '{4'b1010, 16'hE090, 1, 8'h99, 0, 4'b1000, 4'hE};
        vecs[11] = '{4'b0100, 16'h0600, 1, 8'h5A, 6, 4'b0100, 4'h6};

        bus.req_valid  = 4'b0;
        bus.req_sel    = 16'h0;
        bus.rsp_ready  = 4'b0;
        bus.probe_ack  = 1'b0;
        bus.probe_data = 8'h0;

        repeat (3) tick();
        check("reset_outputs",
              {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.probe_en, bus.probe_sel, bus.busy}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {bus.busy, bus.req_ready, bus.probe_en}, 32'h0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset while waiting for the probe ack; a stray ack afterwards must be ignored.
        bus.req_valid = 4'b0001;
        bus.req_sel   = 16'h0008;
        wait_grant("midreset", 4'b0001);
        tick();
        tick();
        check("midreset_in_wait", {bus.busy, bus.probe_en, bus.rsp_valid}, {1'b1, 1'b0, 4'b0});
        bus.req_valid = 4'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.probe_en, bus.probe_sel, bus.busy}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.probe_ack  = 1'b1;
        bus.probe_data = 8'h77;
        tick();
        bus.probe_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midreset_stray_ack", {bus.rsp_valid, bus.busy, bus.rsp_data}, 32'h0);
        end
        run_vec('{4'b1111, 16'h4321, 1, 8'hC3, 0, 4'b0001, 4'h1}, 12);

`ifdef XMR_PROBE_TIMEOUT_EN
        begin
            int n;
            bus.req_valid = 4'b0100;
            bus.req_sel   = 16'h0900;
            wait_grant("timeout", 4'b0100);
            bus.req_valid = 4'b0;
            tick();
            check("timeout_issue", {bus.probe_en, bus.probe_sel}, {1'b1, 4'h9});
            n = 0;
            do begin
                tick();
                n++;
            end while (bus.rsp_valid == 4'b0 && n < 40);
            check("timeout_latency", n, 16);
            check("timeout_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {4'b0100, 8'hFF, 1'b1});
            tick();
            tick();
            bus.probe_ack  = 1'b1;
            bus.probe_data = 8'h12;
            tick();
            bus.probe_ack = 1'b0;
            check("timeout_late_ack", {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {4'b0100, 8'hFF, 1'b1});
            bus.rsp_ready = 4'b0100;
            tick();
            bus.rsp_ready = 4'b0;
            check("timeout_release", {bus.rsp_valid, bus.busy}, 32'h0);

            bus.req_valid = 4'b0001;
            bus.req_sel   = 16'h0005;
            wait_grant("ack_vs_timeout", 4'b0001);
            bus.req_valid = 4'b0;
            tick();
            repeat (15) tick();
            check("ack_vs_timeout_pending", {bus.rsp_valid, bus.busy}, {4'b0, 1'b1});
            bus.probe_ack  = 1'b1;
            bus.probe_data = 8'h3C;
            tick();
            bus.probe_ack = 1'b0;
            check("ack_vs_timeout_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {4'b0001, 8'h3C, 1'b0});
            bus.rsp_ready = 4'b0001;
            tick();
            bus.rsp_ready = 4'b0;
            check("ack_vs_timeout_idle", {bus.rsp_valid, bus.busy}, 32'h0);
        end
`else
        bus.req_valid = 4'b0100;
        bus.req_sel   = 16'h0900;
        wait_grant("no_timeout", 4'b0100);
        bus.req_valid = 4'b0;
        tick();
        check("no_timeout_issue", {bus.probe_en, bus.probe_sel}, {1'b1, 4'h9});
        repeat (40) tick();
        check("no_timeout_hold", {bus.busy, bus.rsp_valid, bus.rsp_err}, {1'b1, 4'b0, 1'b0});
        bus.probe_ack  = 1'b1;
        bus.probe_data = 8'h66;
        tick();
        bus.probe_ack = 1'b0;
        check("no_timeout_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {4'b0100, 8'h66, 1'b0});
        bus.rsp_ready = 4'b0100;
        tick();
        bus.rsp_ready = 4'b0;
        check("no_timeout_idle", {bus.rsp_valid, bus.busy}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xmr_probe_arbiter.md
Name: xmr_probe_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one probe read port between NUM_REQ requesters.
- The probe port reads internal signals that XMR elimination has exported up the hierarchy as ordinary ports.
- Sits in the top level, between debug/observation clients and the exported-signal probe mux.
- Serialises requests one at a time: grant, issue, wait for ack, return response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SEL_W, 4, probe select width (selects one exported signal)
- DATA_W, 8, probe data width
- TIMEOUT, 15, cycles to wait for probe_ack before aborting (used only with the optional feature)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request
- req_sel  input  NUM_REQ*SEL_W  per-requester select; slice i is [i*SEL_W +: SEL_W]
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse
- rsp_valid  output  NUM_REQ  one-hot response valid
- rsp_ready  input  NUM_REQ  per-requester response accept
- rsp_data  output  DATA_W  response data, shared by all requesters
- rsp_err  output  1  response is a timeout abort
- probe_en  output  1  one-cycle probe strobe
- probe_sel  output  SEL_W  probe select, valid while probe_en=1
- probe_ack  input  1  probe data valid; earliest one cycle after probe_en
- probe_data  input  DATA_W  probe read data, qualified by probe_ack
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, probe_en=0, probe_sel=0, busy=0.
  - Reset mid-transaction abandons it; a later stray probe_ack is ignored.
- States: IDLE -> GRANT -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any req_valid, choose g = first set bit searching from rr_ptr+1 upward, with wrap-around modulo NUM_REQ. Latch g and req_sel[g], then go to GRANT.
- GRANT: req_ready[g]=1 for exactly this cycle, then go to ISSUE.
- Requester contract: req_valid/req_sel held stable until req_ready; deassertion before grant is legal only in IDLE.
- ISSUE: probe_en=1 and probe_sel=latched select for one cycle. Clear the wait counter, then go to WAIT.
- WAIT: on probe_ack, latch probe_data into rsp_data, set rsp_err=0, go to RESP. probe_ack in any other state is ignored.
- RESP:
  - rsp_valid[g]=1; rsp_data and rsp_err held stable.
  - When rsp_ready[g]=1: clear rsp_valid, set rr_ptr=g, go to IDLE.
  - rsp_ready on other indices is ignored.
- Latency, with immediate ack and ready:
  - req_valid -> req_ready: 1 cycle.
  - req_ready -> probe_en: 1 cycle.
  - probe_ack -> rsp_valid: 1 cycle.
  - Minimum request-to-request spacing: 5 cycles.
- Simultaneous events:
  - Requests arriving outside IDLE wait.
  - A request from the just-served requester in the same cycle IDLE is re-entered gets lowest priority if others are pending.
  - A single requester repeating alone is re-granted.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,...
- rsp_data keeps its last value outside RESP; rsp_valid never asserts without an ack or a timeout.

Optional Feature:
- Macro: XMR_PROBE_TIMEOUT_EN.
- Defined:
  - A counter (ceil(log2(TIMEOUT+1)) bits) increments each WAIT cycle without probe_ack.
  - On reaching TIMEOUT, go to RESP with rsp_data = all ones and rsp_err=1.
  - probe_ack and timeout in the same cycle: the ack wins (rsp_err=0).
  - A late ack arriving after the abort is ignored.
- Not defined: WAIT holds indefinitely; rsp_err is tied 0; no counter is synthesised.

Test Plan:
- Reset then single request: req_valid=4'b0001, req_sel[0]=4'h3; ack with probe_data=8'hA5 two cycles after probe_en -> req_ready=4'b0001 one cycle, probe_sel=4'h3, rsp_valid=4'b0001, rsp_data=8'hA5, rsp_err=0.
- Round-robin: req_valid=4'b1111 held; ack and rsp_ready immediate -> grant order 0,1,2,3,0; each transaction 5 cycles.
- Skip and wrap: rr_ptr=2 (after serving requester 2), req_valid=4'b0011 -> requester 0 granted, then 1.
- Response backpressure: rsp_ready low for 6 cycles in RESP -> rsp_valid and rsp_data stable; no new probe_en; busy=1 throughout.
- Reset mid-WAIT: rst_n low for one cycle; probe_ack pulses after release -> all outputs 0, state IDLE, ack ignored, no rsp_valid.
- With XMR_PROBE_TIMEOUT_EN, TIMEOUT=15, no ack -> rsp_valid exactly 15 WAIT cycles after entering WAIT, rsp_data=8'hFF, rsp_err=1; a late ack 3 cycles after that is ignored. Without the macro, the same stimulus leaves busy=1 indefinitely.
